// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the RV32I memory stage: funct3 codes, FSM states,
// control-word field positions and the alignment-fault rule.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int CW_RF_WB     = 8;
    localparam int CW_WB_SRC_HI = 7;
    localparam int CW_WB_SRC_LO = 6;
    localparam int CW_PC_SRC    = 5;
    localparam int CW_RD_HI     = 4;
    localparam int CW_RD_LO     = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    // funct3[1:0] is the access size; undefined encodings fault like a misalignment.
    function automatic logic is_misaligned(input logic is_load, input logic [2:0] funct3,
                                           input logic [1:0] addr);
        logic bad_f3;
        bad_f3 = is_load ? ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))
                         : (funct3 >= 3'b011);
        return bad_f3 || ((funct3[1:0] == 2'b01) && addr[0])
                      || ((funct3[1:0] == 2'b10) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align_ext.sv
// Picks the addressed byte/half out of a load word and sign- or zero-extends it.
module load_align_ext
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/gnt/rvalid data-memory port, stalls upstream while an
// access is outstanding, and registers the MEM/WB outputs.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int CW_W = 9
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [XLEN-1:0] ex_target_pc,
    input  logic [4:0]      ex_mem_ctrl,
    input  logic [CW_W-1:0] ex_control_word,
    output logic            mem_stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [XLEN-1:0] mem_data_out,
    output logic [XLEN-1:0] target_pc,
    output logic [XLEN-1:0] ALU_result_mem,
    output logic [CW_W-1:0] control_word_mem,
    output logic            misaligned
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              wb_valid_q, wb_valid_d, misaligned_q, misaligned_d;
    logic [XLEN-1:0]   mem_data_q, mem_data_d, target_pc_q, target_pc_d, alu_q, alu_d;
    logic [CW_W-1:0]   cw_q, cw_d;

    logic              mem_read, mem_write, is_mem, fault, accept, complete;
    logic [2:0]        ex_funct3;
    logic [XLEN-1:0]   lane_wdata, load_data;
    logic [3:0]        lane_be;

    assign mem_read  = ex_mem_ctrl[4];
    assign mem_write = ex_mem_ctrl[3];
    assign ex_funct3 = ex_mem_ctrl[2:0];
    assign is_mem    = mem_read | mem_write;
    assign fault     = is_mem & is_misaligned(mem_read, ex_funct3, ex_alu_result[1:0]);
    assign accept    = ex_valid & is_mem & ~fault;

    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{ex_store_data[7:0]}};
                lane_be    = 4'b0001 << ex_alu_result[1:0];
            end
            2'b01: begin
                lane_wdata = {2{ex_store_data[15:0]}};
                lane_be    = 4'b0011 << {ex_alu_result[1], 1'b0};
            end
            default: begin
                lane_wdata = ex_store_data;
                lane_be    = 4'b1111;
            end
        endcase
    end

    load_align_ext u_load_align_ext (
        .rdata  (dmem_rdata),
        .addr   (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        mem_data_d   = mem_data_q;
        target_pc_d  = target_pc_q;
        alu_d        = alu_q;
        wb_valid_d   = 1'b0;
        cw_d         = '0;
        misaligned_d = 1'b0;
        complete     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = REQ;
                    addr_d   = ex_alu_result;
                    wdata_d  = lane_wdata;
                    be_d     = lane_be;
                    we_d     = mem_write & ~mem_read;
                    funct3_d = ex_funct3;
                end else if (ex_valid) begin
                    complete = 1'b1;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_d  = we_q ? IDLE : WAIT;
                    complete = we_q;
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d    = IDLE;
                    complete   = 1'b1;
                    mem_data_d = load_data;
                end
            end
            default: state_d = IDLE;
        endcase

        // Upstream holds ex_* until completion, so WB fields come straight from them.
        if (complete) begin
            wb_valid_d  = 1'b1;
            alu_d       = ex_alu_result;
            target_pc_d = ex_target_pc;
            cw_d        = ex_control_word;
            if (state_q == IDLE && fault) begin
                cw_d[CW_RF_WB] = 1'b0;
                misaligned_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            we_q         <= 1'b0;
            funct3_q     <= '0;
            wb_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
            mem_data_q   <= '0;
            target_pc_q  <= '0;
            alu_q        <= '0;
            cw_q         <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            wb_valid_q   <= wb_valid_d;
            misaligned_q <= misaligned_d;
            mem_data_q   <= mem_data_d;
            target_pc_q  <= target_pc_d;
            alu_q        <= alu_d;
            cw_q         <= cw_d;
        end
    end

    assign mem_stall        = (state_q == IDLE) ? accept : ~complete;
    assign dmem_req         = (state_q == REQ);
    assign dmem_we          = we_q;
    assign dmem_addr        = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_wdata       = wdata_q;
    assign dmem_be          = be_q;
    assign wb_valid         = wb_valid_q;
    assign mem_data_out     = mem_data_q;
    assign target_pc        = target_pc_q;
    assign ALU_result_mem   = alu_q;
    assign control_word_mem = cw_q;
    assign misaligned       = misaligned_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus random traffic
// against a transaction-level reference model and a scripted memory responder.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_result, ex_store_data, ex_target_pc;
    logic [4:0]  ex_mem_ctrl;
    logic [8:0]  ex_control_word;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid, misaligned;
    logic [31:0] mem_data_out, target_pc, ALU_result_mem;
    logic [8:0]  control_word_mem;

    int n_cmp = 0;
    int n_err = 0;
    int n_txn = 0;

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_target_pc(ex_target_pc), .ex_mem_ctrl(ex_mem_ctrl),
        .ex_control_word(ex_control_word), .mem_stall(mem_stall), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .mem_data_out(mem_data_out), .target_pc(target_pc),
        .ALU_result_mem(ALU_result_mem), .control_word_mem(control_word_mem),
        .misaligned(misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_fault(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        int size;
        size = int'(f3[1:0]);
        if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
        if (!ld && f3 >= 3) return 1'b1;
        if (size == 1 && (a % 2) != 0) return 1'b1;
        if (size == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rdata);
        logic [31:0] w;
        w = rdata >> ((a % 4) * 8);
        case (f3)
            3'd0:    return (w & 32'hFF)   | ((w & 32'h80)   != 0 ? 32'hFFFF_FF00 : 32'h0);
            3'd1:    return (w & 32'hFFFF) | ((w & 32'h8000) != 0 ? 32'hFFFF_0000 : 32'h0);
            3'd4:    return w & 32'hFF;
            3'd5:    return w & 32'hFFFF;
            default: return rdata;
        endcase
    endfunction

    // One instruction from issue to WB, with the memory granting after gd idle REQ
    // cycles and returning data rd cycles after the grant.
    task automatic run_instr(input logic [4:0] ctrl, input logic [31:0] alu, input logic [31:0] sd,
                             input logic [31:0] tpc, input logic [8:0] cw, input int gd,
                             input int rd, input logic [31:0] rdata);
        bit ld, st, flt, acc, done, granted;
        int exp_stall, stall_cnt, req_cnt, wait_cnt, cyc;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [8:0]  exp_cw;
        ld  = ctrl[4];
        st  = ctrl[3] && !ctrl[4];
        flt = (ld || st) && model_fault(ld, ctrl[2:0], alu);
        acc = (ld || st) && !flt;
        exp_stall = !acc ? 0 : (st ? 1 + gd : 1 + gd + rd);
        case (ctrl[1:0])
            2'd0:    begin exp_be = 4'(1 << (alu % 4)); exp_wdata = sd[7:0] * 32'h0101_0101; end
            2'd1:    begin exp_be = 4'(3 << (alu % 4)); exp_wdata = sd[15:0] * 32'h0001_0001; end
            default: begin exp_be = 4'hF;               exp_wdata = sd; end
        endcase
        exp_cw = flt ? (cw & 9'h0FF) : cw;

        ex_valid = 1'b1; ex_mem_ctrl = ctrl; ex_alu_result = alu; ex_store_data = sd;
        ex_target_pc = tpc; ex_control_word = cw; dmem_rdata = rdata;
        done = 0; granted = 0; stall_cnt = 0; req_cnt = 0; wait_cnt = 0; cyc = 0;
        while (!done && cyc < 40) begin
            cyc++;
            @(negedge clk);
            if (granted) begin
                check("req_after_gnt", 32'(dmem_req), 32'd0);
                wait_cnt++;
            end
            if (!acc) check("req_nonmem", 32'(dmem_req), 32'd0);
            if (dmem_req) begin
                check("addr", dmem_addr, {alu[31:2], 2'b00});
                check("we", 32'(dmem_we), 32'(st));
                if (st) begin
                    check("wdata", dmem_wdata, exp_wdata);
                    check("be", 32'(dmem_be), 32'(exp_be));
                end
                dmem_gnt = (req_cnt == gd);
                req_cnt++;
            end
            dmem_rvalid = granted && (wait_cnt == rd);
            #1;
            if (mem_stall) stall_cnt++;
            else done = 1;
            if (dmem_gnt) granted = 1;
            @(posedge clk);
            #1;
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (!done) check("wb_in_stall", 32'(wb_valid), 32'd0);
        end
        if (!done) check("timeout", 32'd0, 32'd1);
        check("wb_valid", 32'(wb_valid), 32'd1);
        check("alu_result", ALU_result_mem, alu);
        check("target_pc", target_pc, tpc);
        check("control_word", 32'(control_word_mem), 32'(exp_cw));
        check("misaligned", 32'(misaligned), 32'(flt));
        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        if (ld && acc) check("load_data", mem_data_out, model_load(ctrl[2:0], alu, rdata));

        ex_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bubble_wb", 32'(wb_valid), 32'd0);
        check("bubble_cw", 32'(control_word_mem), 32'd0);
        n_txn++;
        $display("txn %0d: ctrl=%b addr=%h sd=%h gd=%0d rd=%0d fault=%0d stalls=%0d data=%h",
                 n_txn, ctrl, alu, sd, gd, rd, flt, stall_cnt, mem_data_out);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(dmem_req), 32'd0);
        check({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        check({tag, "_misaligned"}, 32'(misaligned), 32'd0);
        check({tag, "_data"}, mem_data_out, 32'd0);
        check({tag, "_tpc"}, target_pc, 32'd0);
        check({tag, "_alu"}, ALU_result_mem, 32'd0);
        check({tag, "_cw"}, 32'(control_word_mem), 32'd0);
    endtask

    task automatic reset_in_wait();
        ex_valid = 1'b1; ex_mem_ctrl = 5'b10010; ex_alu_result = 32'h5000;
        ex_store_data = 32'h0; ex_target_pc = 32'h77; ex_control_word = 9'h1_0A;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_req_up", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        @(negedge clk);
        check("rst_wait_req", 32'(dmem_req), 32'd0);
        #2;
        rst_n = 1'b0;
        ex_valid = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        check("rst_rvalid_wb", 32'(wb_valid), 32'd0);
        check("rst_rvalid_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
        check("rst_after_wb", 32'(wb_valid), 32'd0);
        n_txn++;
        $display("txn %0d: reset while waiting for load data, late rvalid", n_txn);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_target_pc = '0; ex_mem_ctrl = '0; ex_control_word = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        #12;
        check_reset_outputs("reset");
        check("reset_stall", 32'(mem_stall), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_instr(5'b00000, 32'h1234, 32'h0, 32'h100, 9'h105, 0, 1, 32'h0);
        run_instr(5'b01000, 32'h1003, 32'hAB, 32'h104, 9'h000, 0, 1, 32'h0);
        run_instr(5'b10000, 32'h2001, 32'h0, 32'h108, 9'h1_2A, 2, 3, 32'h0000_80FF);
        check("lb_const", mem_data_out, 32'hFFFF_FF80);
        run_instr(5'b10100, 32'h2001, 32'h0, 32'h10C, 9'h1_2B, 2, 3, 32'h0000_80FF);
        check("lbu_const", mem_data_out, 32'h0000_0080);
        run_instr(5'b10010, 32'h3002, 32'h0, 32'h110, 9'h1_4C, 0, 1, 32'h0);
        reset_in_wait();
        run_instr(5'b10001, 32'h4002, 32'h0, 32'h114, 9'h1_2D, 0, 1, 32'h8001_0000);
        check("lh_const", mem_data_out, 32'hFFFF_8001);
        run_instr(5'b01010, 32'h4000, 32'hCAFE_F00D, 32'h118, 9'h000, 0, 1, 32'h0);

        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [4:0] ctrl;
            kind = int'($urandom_range(0, 3));
            ctrl = {kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom_range(0, 7))};
            if (kind == 0) ctrl[2:0] = 3'($urandom);
            run_instr(ctrl, $urandom, $urandom, $urandom, 9'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
